// File: rtl/reflet_int_to_float_seq.sv
`default_nettype none
// ============================================================================
//  Module   : reflet_int_to_float_seq
//  Brief    : Sequential valid/ready integer-to-float converter. Normalises
//             one bit per cycle, then rounds (truncate or nearest-even) and
//             packs a half, single or double precision result with inexact
//             and overflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module reflet_int_to_float_seq #(
  parameter int INT_SIZE   = 16,
  parameter int FLOAT_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT_SIZE-1:0]   int_in,
  input  logic                  in_signed,
  input  logic                  in_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOAT_SIZE-1:0] float_out,
  output logic                  flag_inexact,
  output logic                  flag_overflow
);

  // Float field geometry for the selected format.
  localparam int EXP_W   = (FLOAT_SIZE == 16) ? 5  : (FLOAT_SIZE == 64) ? 11 : 8;
  localparam int MAN_W   = (FLOAT_SIZE == 16) ? 10 : (FLOAT_SIZE == 64) ? 52 : 23;
  localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  // Bits below the leading one, padded so mantissa, guard and at least one
  // sticky bit always exist even for narrow integers.
  localparam int FRAC_W = INT_SIZE - 1;
  localparam int EXT_W  = (FRAC_W > MAN_W + 2) ? FRAC_W : MAN_W + 2;

  // Exponent counter holds 0..INT_SIZE-1; biased exponent must hold
  // INT_SIZE + BIAS + 1 without wrapping and still compare against EXP_MAX.
  localparam int CNT_W  = (INT_SIZE > 2) ? $clog2(INT_SIZE) : 1;
  localparam int BE_RAW = $clog2(INT_SIZE + BIAS + 2) + 1;
  localparam int BE_W   = (BE_RAW > EXP_W + 1) ? BE_RAW : EXP_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_sign;
  logic                  r_round;
  logic [INT_SIZE-1:0]   r_mag;
  logic [CNT_W-1:0]      r_cnt;
  logic [FLOAT_SIZE-1:0] r_float;
  logic                  r_inexact;
  logic                  r_overflow;

  logic                  w_neg;
  logic [INT_SIZE-1:0]   w_abs;
  logic [FRAC_W-1:0]     w_frac;
  logic [EXT_W-1:0]      w_ext;
  logic [MAN_W-1:0]      w_man;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_inc;
  logic [MAN_W:0]        w_man_sum;
  logic                  w_carry;
  logic [BE_W-1:0]       w_bexp;
  logic                  w_ovf;

  // Operand capture: sign and absolute value (most negative maps to 2^(n-1)).
  assign w_neg = in_signed & int_in[INT_SIZE-1];
  assign w_abs = w_neg ? (INT_SIZE'(0) - int_in) : int_in;

  // Rounding datapath on the normalised magnitude (leading one at the MSB).
  assign w_frac    = r_mag[INT_SIZE-2:0];
  assign w_ext     = EXT_W'(w_frac) << (EXT_W - FRAC_W);
  assign w_man     = w_ext[EXT_W-1 -: MAN_W];
  assign w_guard   = w_ext[EXT_W-1-MAN_W];
  assign w_sticky  = |w_ext[EXT_W-MAN_W-2:0];
  assign w_inc     = r_round & w_guard & (w_sticky | w_man[0]);
  assign w_man_sum = {1'b0, w_man} + (MAN_W+1)'(w_inc);
  assign w_carry   = w_man_sum[MAN_W];
  assign w_bexp    = BE_W'(r_cnt) + BE_W'(BIAS) + BE_W'(w_carry);
  assign w_ovf     = (w_bexp >= BE_W'(EXP_MAX));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (w_abs == '0) ? S_DONE : S_NORM;
        end
      end
      S_NORM: begin
        if (r_mag[INT_SIZE-1]) begin
          w_next = S_ROUND;
        end
      end
      S_ROUND: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, iterative normalisation and result packing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sign     <= 1'b0;
      r_round    <= 1'b0;
      r_mag      <= '0;
      r_cnt      <= '0;
      r_float    <= '0;
      r_inexact  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign  <= w_neg;
            r_mag   <= w_abs;
            r_round <= in_round;
            r_cnt   <= CNT_W'(INT_SIZE - 1);
            if (w_abs == '0) begin
              r_float    <= '0;
              r_inexact  <= 1'b0;
              r_overflow <= 1'b0;
            end
          end
        end
        S_NORM: begin
          if (!r_mag[INT_SIZE-1]) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_ROUND: begin
          if (w_ovf) begin
            r_float    <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r_inexact  <= 1'b1;
            r_overflow <= 1'b1;
          end else begin
            r_float    <= {r_sign, w_bexp[EXP_W-1:0], w_man_sum[MAN_W-1:0]};
            r_inexact  <= w_guard | w_sticky;
            r_overflow <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign float_out     = r_float;
  assign flag_inexact  = r_inexact;
  assign flag_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_reflet_int_to_float_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reflet_int_to_float_seq
//  Brief    : Self-checking bench for reflet_int_to_float_seq. Three DUT
//             configurations (16->f32, 32->f32, 32->f16) share one stimulus
//             path selected by sel; results are compared to an arithmetic
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reflet_int_to_float_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic        in_signed;
  logic        in_round;
  logic [31:0] int_drv;
  int          sel;

  int total  = 0;
  int passes = 0;
  logic [63:0] last_float;

  always #5 clk = ~clk;

  logic        ir0, ov0, ix0, of0;
  logic [31:0] f0;
  logic        ir1, ov1, ix1, of1;
  logic [31:0] f1;
  logic        ir2, ov2, ix2, of2;
  logic [15:0] f2;

  reflet_int_to_float_seq #(.INT_SIZE(16), .FLOAT_SIZE(32)) u_i16_f32 (
    .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 0)), .in_ready(ir0),
    .int_in(int_drv[15:0]), .in_signed(in_signed), .in_round(in_round),
    .out_valid(ov0), .out_ready(out_ready && (sel == 0)), .float_out(f0),
    .flag_inexact(ix0), .flag_overflow(of0)
  );

  reflet_int_to_float_seq #(.INT_SIZE(32), .FLOAT_SIZE(32)) u_i32_f32 (
    .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 1)), .in_ready(ir1),
    .int_in(int_drv), .in_signed(in_signed), .in_round(in_round),
    .out_valid(ov1), .out_ready(out_ready && (sel == 1)), .float_out(f1),
    .flag_inexact(ix1), .flag_overflow(of1)
  );

  reflet_int_to_float_seq #(.INT_SIZE(32), .FLOAT_SIZE(16)) u_i32_f16 (
    .clk(clk), .reset(reset), .in_valid(in_valid && (sel == 2)), .in_ready(ir2),
    .int_in(int_drv), .in_signed(in_signed), .in_round(in_round),
    .out_valid(ov2), .out_ready(out_ready && (sel == 2)), .float_out(f2),
    .flag_inexact(ix2), .flag_overflow(of2)
  );

  logic        m_in_ready, m_out_valid, m_inx, m_ovf;
  logic [63:0] m_float;

  // Route the selected instance's outputs to a common observation point.
  always_comb begin
    m_in_ready  = 1'b0;
    m_out_valid = 1'b0;
    m_inx       = 1'b0;
    m_ovf       = 1'b0;
    m_float     = '0;
    case (sel)
      0: begin m_in_ready = ir0; m_out_valid = ov0; m_inx = ix0; m_ovf = of0; m_float = {32'd0, f0}; end
      1: begin m_in_ready = ir1; m_out_valid = ov1; m_inx = ix1; m_ovf = of1; m_float = {32'd0, f1}; end
      2: begin m_in_ready = ir2; m_out_valid = ov2; m_inx = ix2; m_ovf = of2; m_float = {48'd0, f2}; end
      default: begin end
    endcase
  end

  // Reference: exact integer value, then rounding by remainder comparison.
  task automatic model(input int s, input logic [31:0] raw, input logic sgn, input logic rnd,
                       output logic [63:0] f, output logic inx, output logic ovf, output int lat);
    int n, mw, ew, bias, e, sh, be;
    logic [63:0] v, mag, q, rem, half;
    logic neg;
    n    = (s == 0) ? 16 : 32;
    mw   = (s == 2) ? 10 : 23;
    ew   = (s == 2) ? 5 : 8;
    bias = (1 << (ew - 1)) - 1;
    v    = {32'd0, raw} & ((64'd1 << n) - 64'd1);
    neg  = sgn && v[n-1];
    mag  = neg ? ((64'd1 << n) - v) : v;
    f = '0; inx = 1'b0; ovf = 1'b0; lat = 1;
    if (mag != 64'd0) begin
      e = 63;
      while (mag[e] == 1'b0) e--;
      lat = (n - 1 - e) + 3;
      if (e <= mw) begin
        q = mag << (mw - e);
      end else begin
        sh   = e - mw;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 64'd0);
        if (rnd && ((rem > half) || ((rem == half) && q[0]))) q = q + 64'd1;
      end
      if (q == (64'd1 << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      be = e + bias;
      if (be >= (1 << ew) - 1) begin
        ovf = 1'b1;
        inx = 1'b1;
        f = (64'(neg) << (ew + mw)) | (((64'd1 << ew) - 64'd1) << mw);
      end else begin
        f = (64'(neg) << (ew + mw)) | (64'(be) << mw) | (q - (64'd1 << mw));
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One full transaction: accept, wait for result, optional stall, drain.
  task automatic conv(input int s, input logic [31:0] raw, input logic sgn, input logic rnd, input int hold);
    logic [63:0] ef;
    logic ei, eo;
    int lat, edges;
    model(s, raw, sgn, rnd, ef, ei, eo, lat);
    sel = s;
    #0;
    chk("in_ready_idle", 64'(m_in_ready), 64'd1);
    int_drv = raw; in_signed = sgn; in_round = rnd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; int_drv = ~raw; in_signed = ~sgn; in_round = ~rnd;
    edges = 1;
    while (!m_out_valid && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", 64'(edges), 64'(lat));
    chk("out_valid", 64'(m_out_valid), 64'd1);
    chk("float_out", m_float, ef);
    chk("flag_inexact", 64'(m_inx), 64'(ei));
    chk("flag_overflow", 64'(m_ovf), 64'(eo));
    chk("in_ready_busy", 64'(m_in_ready), 64'd0);
    last_float = m_float;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("stall_float", m_float, ef);
      chk("stall_inexact", 64'(m_inx), 64'(ei));
      chk("stall_overflow", 64'(m_ovf), 64'(eo));
      chk("stall_out_valid", 64'(m_out_valid), 64'd1);
      chk("stall_in_ready", 64'(m_in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(m_out_valid), 64'd0);
    chk("in_ready_after", 64'(m_in_ready), 64'd1);
  endtask

  task automatic dconv(input string tag, input int s, input logic [31:0] raw, input logic sgn,
                       input logic rnd, input logic [63:0] expf);
    conv(s, raw, sgn, rnd, 0);
    chk(tag, last_float, expf);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_signed = 1'b0; in_round = 1'b0; int_drv = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(m_in_ready), 64'd1);
    chk("rst_out_valid", 64'(m_out_valid), 64'd0);
    chk("rst_float", m_float, 64'd0);
    chk("rst_flags", {62'd0, m_inx, m_ovf}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    dconv("s16_5",        0, 32'h0000_0005, 1'b1, 1'b1, 64'h40A0_0000);
    dconv("s16_m1",       0, 32'h0000_FFFF, 1'b1, 1'b1, 64'hBF80_0000);
    dconv("s16_8000",     0, 32'h0000_8000, 1'b1, 1'b1, 64'hC700_0000);
    dconv("s16_zero",     0, 32'h0000_0000, 1'b1, 1'b1, 64'h0000_0000);
    dconv("u16_ffff",     0, 32'h0000_FFFF, 1'b0, 1'b1, 64'h477F_FF00);
    dconv("u16_8000",     0, 32'h0000_8000, 1'b0, 1'b1, 64'h4700_0000);
    dconv("i32_rne_tie",  1, 32'h0100_0003, 1'b0, 1'b1, 64'h4B80_0002);
    dconv("i32_trunc",    1, 32'h0100_0003, 1'b0, 1'b0, 64'h4B80_0001);
    dconv("i32_rne_down", 1, 32'h0100_0001, 1'b0, 1'b1, 64'h4B80_0000);
    dconv("i32_carry",    1, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'h4F80_0000);
    dconv("h_ovf_pos",    2, 32'h0001_0000, 1'b0, 1'b1, 64'h0000_7C00);
    dconv("h_ovf_neg",    2, 32'hFFFF_0000, 1'b1, 1'b1, 64'h0000_FC00);

    conv(1, 32'h0100_0003, 1'b0, 1'b1, 10);

    // Leave a nonzero result in the 16-bit instance, then reset mid-NORM.
    dconv("pre_rst", 0, 32'h0000_FFFF, 1'b0, 1'b1, 64'h477F_FF00);
    sel = 0;
    int_drv = 32'd1; in_signed = 1'b0; in_round = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(m_out_valid), 64'd0);
    chk("arst_in_ready", 64'(m_in_ready), 64'd1);
    chk("arst_float", m_float, 64'd0);
    chk("arst_inexact", 64'(m_inx), 64'd0);
    chk("arst_overflow", 64'(m_ovf), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    dconv("post_rst_7", 0, 32'h0000_0007, 1'b0, 1'b1, 64'h40E0_0000);

    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 25; k++) begin
        logic [31:0] r;
        r = $urandom >> $urandom_range(0, 31);
        conv(s, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
